affine_map_gen: RTL
===================

AFFINE_MAP_GEN -- requirements
Module: affine_map_gen

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 640, meaning output columns per frame.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 480, meaning output rows per frame.
REQ-003 SHALL have parameter FRAC, default 12, meaning fractional bits of all coefficients and map outputs.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  frame request pulse.
REQ-007 SHALL have ports m00, m01, m10, m11  input  24 each  signed Q11.FRAC matrix coefficients.
REQ-008 SHALL have ports tx, ty  input  32 each  signed Q19.FRAC translation.
REQ-009 SHALL have port map_ready  input  1  downstream remap accepts the coordinate.
REQ-010 SHALL have port map_valid  output  1  coordinate on map_x/map_y is valid.
REQ-011 SHALL have ports map_x, map_y  output  24 each  unsigned Q12.FRAC source coordinate.
REQ-012 SHALL have port map_last  output  1  current coordinate is the last of the frame.
REQ-013 SHALL have port busy  output  1  frame in progress.
REQ-014 SHALL have port done  output  1  one-cycle end-of-frame pulse.

Function
REQ-015 SHALL generate, for output pixel (x,y) in raster order (x fastest), src_x = m00*x + m01*y + tx and src_y = m10*x + m11*y + ty.
REQ-016 SHALL compute src_x/src_y incrementally: add-only; no multipliers; 40-bit signed row and column accumulators.
REQ-017 SHALL saturate each output: src < 0 -> 0; src > 24'hFFFFFF -> 24'hFFFFFF; else src[23:0].
REQ-018 SHALL use states IDLE, RUN, DONE.
REQ-019 IDLE: map_valid=0, busy=0; start=1 latches m00..ty, sets x=y=0, goes to RUN.
REQ-020 SHALL assert map_valid with the (0,0) coordinate on the cycle after start is sampled.
REQ-021 RUN: a transfer occurs on any cycle with map_valid=1 and map_ready=1.
REQ-022 SHALL hold map_x, map_y and map_last stable while map_valid=1 and map_ready=0.
REQ-023 On each transfer, SHALL present the next raster coordinate on the following cycle with map_valid=1, allowing one transfer per cycle under continuous map_ready.
REQ-024 SHALL handle row wrap: on the transfer at x=IMAGE_WIDTH-1, x wraps to 0 and y increments; the next point is based on the row accumulator plus m01/m11.
REQ-025 SHALL drive map_last=1 only while presenting (IMAGE_WIDTH-1, IMAGE_HEIGHT-1).
REQ-026 On the map_last transfer, SHALL clear map_valid next cycle and enter DONE.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 SHALL keep busy=1 in RUN and DONE.
REQ-029 SHALL ignore start outside IDLE.
REQ-030 SHALL ignore coefficient changes after the latch, until the next accepted start.
REQ-031 SHALL produce exactly IMAGE_WIDTH*IMAGE_HEIGHT transfers per frame.
REQ-032 Simultaneous start and DONE->IDLE: start in the DONE cycle is ignored; start is accepted only when sampled in IDLE.

Reset
REQ-033 While rst_n=0 at a clock edge, SHALL enter IDLE.
REQ-034 Reset values: map_valid=0, map_x=0, map_y=0, map_last=0, busy=0, done=0; counters and accumulators cleared.
REQ-035 Reset mid-frame SHALL abandon the frame; no done pulse; the next frame requires a new start.

Verification
REQ-036 Identity, W=4 H=3 FRAC=12: m00=m11=4096, m01=m10=0, tx=ty=0, map_ready=1 -> 12 transfers in 12 consecutive cycles; map_x = 0,4096,8192,12288 repeating; map_y steps 0/4096/8192 per row; map_last on the 12th; done one cycle later.
REQ-037 Backpressure: identity config, map_ready toggled 1,0,0,1 -> coordinate held unchanged during the low cycles; no point skipped or duplicated; total 12 transfers.
REQ-038 Saturation: tx=-8192, m00=4096 -> map_x=0,0,0,4096 on row 0; tx=32'h01000000 -> map_x=24'hFFFFFF for all points.
REQ-039 Shear/row wrap: m01=2048, others identity -> row 1 starts at map_x=2048, row 2 at map_x=4096.
REQ-040 Start during busy ignored: second start pulse at the 5th transfer -> still exactly 12 transfers; one done pulse.
REQ-041 Reset mid-frame: rst_n=0 after the 6th transfer -> next cycle map_valid=0, busy=0, no done; a new start restarts at (0,0).

Source files
------------

// File: rtl/affine_map_gen.sv
// affine_map_gen: raster-order affine source-coordinate generator.
// For each output pixel (x,y) it emits src = M*[x y]' + t, computed with
// adders only (row/column accumulators), saturated to unsigned Q12.FRAC,
// over a valid/ready handshake with a per-frame start/busy/done control.
module affine_map_gen #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FRAC         = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] m00,
  input  logic [23:0] m01,
  input  logic [23:0] m10,
  input  logic [23:0] m11,
  input  logic [31:0] tx,
  input  logic [31:0] ty,
  input  logic        map_ready,
  output logic        map_valid,
  output logic [23:0] map_x,
  output logic [23:0] map_y,
  output logic        map_last,
  output logic        busy,
  output logic        done
);

  localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Sign-extend a Q11.FRAC coefficient into the 40-bit accumulator domain.
  function automatic logic signed [39:0] sx24(input logic [23:0] v);
    return {{16{v[23]}}, v};
  endfunction

  // Sign-extend a Q19.FRAC translation into the 40-bit accumulator domain.
  function automatic logic signed [39:0] sx32(input logic [31:0] v);
    return {{8{v[31]}}, v};
  endfunction

  // Clamp a signed accumulator to the unsigned 24-bit output range.
  function automatic logic [23:0] sat24(input logic signed [39:0] v);
    logic [23:0] r;
    if (v[39]) begin
      r = 24'h000000;
    end else if (v[38:24] != 15'h0000) begin
      r = 24'hFFFFFF;
    end else begin
      r = v[23:0];
    end
    return r;
  endfunction

  state_t             state_r;
  logic signed [39:0] m00_r, m01_r, m10_r, m11_r;
  logic signed [39:0] row_x_r, row_y_r, col_x_r, col_y_r;
  logic [XW-1:0]      x_r;
  logic [YW-1:0]      y_r;
  logic               map_valid_r, map_last_r, busy_r, done_r;
  logic [23:0]        map_x_r, map_y_r;

  logic signed [39:0] nrow_x_s, nrow_y_s, ncol_x_s, ncol_y_s;
  logic [XW-1:0]      nx_s;
  logic [YW-1:0]      ny_s;
  logic               nlast_s;

  // Next raster point: step the column accumulators, or on a row wrap
  // step the row accumulators and restart the columns from them.
  always_comb begin
    nrow_x_s = row_x_r;
    nrow_y_s = row_y_r;
    ncol_x_s = col_x_r;
    ncol_y_s = col_y_r;
    nx_s     = x_r;
    ny_s     = y_r;
    if (x_r == X_LAST) begin
      nrow_x_s = row_x_r + m01_r;
      nrow_y_s = row_y_r + m11_r;
      ncol_x_s = row_x_r + m01_r;
      ncol_y_s = row_y_r + m11_r;
      nx_s     = {XW{1'b0}};
      ny_s     = y_r + YW'(1);
    end else begin
      ncol_x_s = col_x_r + m00_r;
      ncol_y_s = col_y_r + m10_r;
      nx_s     = x_r + XW'(1);
    end
    nlast_s = (nx_s == X_LAST) && (ny_s == Y_LAST);
  end

  // Frame control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      m00_r       <= 40'sd0;
      m01_r       <= 40'sd0;
      m10_r       <= 40'sd0;
      m11_r       <= 40'sd0;
      row_x_r     <= 40'sd0;
      row_y_r     <= 40'sd0;
      col_x_r     <= 40'sd0;
      col_y_r     <= 40'sd0;
      x_r         <= {XW{1'b0}};
      y_r         <= {YW{1'b0}};
      map_valid_r <= 1'b0;
      map_last_r  <= 1'b0;
      map_x_r     <= 24'h000000;
      map_y_r     <= 24'h000000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          map_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          if (start) begin
            m00_r       <= sx24(m00);
            m01_r       <= sx24(m01);
            m10_r       <= sx24(m10);
            m11_r       <= sx24(m11);
            row_x_r     <= sx32(tx);
            row_y_r     <= sx32(ty);
            col_x_r     <= sx32(tx);
            col_y_r     <= sx32(ty);
            x_r         <= {XW{1'b0}};
            y_r         <= {YW{1'b0}};
            map_x_r     <= sat24(sx32(tx));
            map_y_r     <= sat24(sx32(ty));
            map_last_r  <= (X_LAST == {XW{1'b0}}) && (Y_LAST == {YW{1'b0}});
            map_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= S_RUN;
          end
        end
        S_RUN: begin
          if (map_valid_r && map_ready) begin
            if (map_last_r) begin
              map_valid_r <= 1'b0;
              map_last_r  <= 1'b0;
              done_r      <= 1'b1;
              state_r     <= S_DONE;
            end else begin
              row_x_r    <= nrow_x_s;
              row_y_r    <= nrow_y_s;
              col_x_r    <= ncol_x_s;
              col_y_r    <= ncol_y_s;
              x_r        <= nx_s;
              y_r        <= ny_s;
              map_x_r    <= sat24(ncol_x_s);
              map_y_r    <= sat24(ncol_y_s);
              map_last_r <= nlast_s;
            end
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          map_valid_r <= 1'b0;
          map_last_r  <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign map_valid = map_valid_r;
  assign map_x     = map_x_r;
  assign map_y     = map_y_r;
  assign map_last  = map_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
